// File: rtl/mant_divider_seq.sv
// Sequential restoring radix-2 unsigned divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// Latency: W+1 cycles from the accepting edge to done (1 cycle for divide-by-zero / overflow).
// Backpressure: none; start is only accepted in IDLE, requests while busy are dropped (no queuing).
// Optional build macro MANT_DIV_STICKY_EN adds sticky_out (OR of the final remainder, forced to 1 on exceptions).
module mant_divider_seq #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [2*DATA_WIDTH-1:0]   a_in,
    input  logic [DATA_WIDTH-1:0]     b_in,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     quot_out,
    output logic [DATA_WIDTH-1:0]     rem_out,
    output logic                      div_by_zero,
    output logic                      overflow
`ifdef MANT_DIV_STICKY_EN
    ,
    output logic                      sticky_out
`endif
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W:0]      r_q, r_d;          // partial remainder, one bit of headroom for the shift
    logic [W-1:0]    dsh_q, dsh_d;      // low dividend half, consumed MSB first
    logic [W-1:0]    quo_q, quo_d;      // quotient under construction
    logic [W-1:0]    b_q, b_d;          // divisor captured at accept
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    qout_q, qout_d;
    logic [W-1:0]    rout_q, rout_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;
`ifdef MANT_DIV_STICKY_EN
    logic            sticky_q, sticky_d;
`endif

    // Iteration datapath signals
    logic [W-1:0]    a_hi;
    logic [W-1:0]    a_lo;
    logic [W:0]      t_shift;
    logic            q_bit;
    logic [W:0]      r_iter;
    logic [W-1:0]    q_iter;

    assign a_hi = a_in[2*W-1:W];
    assign a_lo = a_in[W-1:0];

    // One restoring step: shift in the next dividend bit, subtract the divisor when it fits.
    // A set top bit of r_q would mean the shifted value already exceeds any W-bit divisor.
    always_comb begin
        t_shift = {r_q[W-1:0], dsh_q[W-1]};
        q_bit   = r_q[W] | (t_shift >= {1'b0, b_q});
        r_iter  = q_bit ? (t_shift - {1'b0, b_q}) : t_shift;
        q_iter  = {quo_q[W-2:0], q_bit};
    end

    // Next-state and datapath update; defaults hold every register.
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        dsh_d    = dsh_q;
        quo_d    = quo_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        qout_d   = qout_q;
        rout_d   = rout_q;
        dbz_d    = dbz_q;
        ovf_d    = ovf_q;
`ifdef MANT_DIV_STICKY_EN
        sticky_d = sticky_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    b_d   = b_in;
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
                    if (b_in == '0) begin
                        // Exceptions resolve at accept; result registers load the saturated value now.
                        dbz_d    = 1'b1;
                        qout_d   = '1;
                        rout_d   = '0;
`ifdef MANT_DIV_STICKY_EN
                        sticky_d = 1'b1;
`endif
                        state_d  = S_DONE;
                    end else if (a_hi >= b_in) begin
                        ovf_d    = 1'b1;
                        qout_d   = '1;
                        rout_d   = '0;
`ifdef MANT_DIV_STICKY_EN
                        sticky_d = 1'b1;
`endif
                        state_d  = S_DONE;
                    end else begin
                        r_d     = {1'b0, a_hi};
                        dsh_d   = a_lo;
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                r_d   = r_iter;
                dsh_d = {dsh_q[W-2:0], 1'b0};
                quo_d = q_iter;
                if (cnt_q == CNT_LAST) begin
                    // Final step: publish results on the same edge that enters DONE.
                    qout_d   = q_iter;
                    rout_d   = r_iter[W-1:0];
`ifdef MANT_DIV_STICKY_EN
                    sticky_d = |r_iter;
`endif
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            r_q      <= '0;
            dsh_q    <= '0;
            quo_q    <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            qout_q   <= '0;
            rout_q   <= '0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef MANT_DIV_STICKY_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            dsh_q    <= dsh_d;
            quo_q    <= quo_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            qout_q   <= qout_d;
            rout_q   <= rout_d;
            dbz_q    <= dbz_d;
            ovf_q    <= ovf_d;
`ifdef MANT_DIV_STICKY_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign quot_out    = qout_q;
    assign rem_out     = rout_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
`ifdef MANT_DIV_STICKY_EN
    assign sticky_out  = sticky_q;
`endif

endmodule
